// File: rtl/uart_pkg.sv
// Shared UART types: parity mode, receiver state encoding and small bit helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_SPACE = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP1      = 3'd4,
        ST_STOP2      = 3'd5,
        ST_BREAK_WAIT = 3'd6
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent, given the XOR of the data bits.
    function automatic logic par_expected(input parity_e mode, input logic data_xor);
        case (mode)
            PAR_EVEN: return data_xor;
            PAR_ODD:  return ~data_xor;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick divider; i_restart realigns the phase to a detected start edge.
module uart_baud_gen #(
    parameter int SystemClockFreq = 133_000_000,
    parameter int BaudRate        = 115200,
    parameter int OverSample      = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int RawDiv = SystemClockFreq / (BaudRate * OverSample);
    localparam int Div    = (RawDiv < 1) ? 1 : RawDiv;
    localparam int CW     = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [CW-1:0] Last = CW'(Div - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == Last);
    assign o_tick = w_wrap & ~i_restart;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// UART receiver: majority-voted oversampling, parity/stop/break checks and a
// single-entry holding register with valid/ready hand-off and sticky overrun.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int DataLength      = 8,
    parameter int OverSample      = 16,
    parameter int BaudRate        = 115200,
    parameter int SystemClockFreq = 133_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx,
    input  parity_e               i_parity,
    input  logic                  i_two_stop,
    output logic [DataLength-1:0] o_rx_data,
    output logic                  o_rx_valid,
    input  logic                  i_rx_ready,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_break,
    output logic                  o_overrun,
    input  logic                  i_err_clr,
    output logic                  o_rts,
    output rx_state_e             o_state
);

    localparam int TCW = $clog2(OverSample);
    localparam logic [TCW-1:0] T_S0  = TCW'(OverSample / 2 - 1);
    localparam logic [TCW-1:0] T_S1  = TCW'(OverSample / 2);
    localparam logic [TCW-1:0] T_DEC = TCW'(OverSample / 2 + 1);
    localparam logic [TCW-1:0] T_END = TCW'(OverSample - 1);

    logic r_sync1, r_sync2, r_rx_prev;
    logic w_rx, w_fall, w_restart, w_tick, w_decide, w_end, w_maj, w_break;
    logic w_done, w_ferr_fin, w_brk_fin;

    rx_state_e             r_state, w_next;
    logic [TCW-1:0]        r_tick_cnt;
    logic [3:0]            r_bit_cnt;
    logic                  r_s0, r_s1, r_bit;
    logic [DataLength-1:0] r_shift;
    parity_e               r_par_mode;
    logic                  r_two_stop, r_par_bit, r_perr, r_ferr;
    logic [DataLength-1:0] r_rx_data;
    logic                  r_valid, r_perr_h, r_ferr_h, r_brk_h, r_ovr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx      = r_sync2;
    assign w_fall    = r_rx_prev & ~r_sync2;
    assign w_restart = (r_state == ST_IDLE) && w_fall;
    assign w_decide  = w_tick && (r_tick_cnt == T_DEC);
    assign w_end     = w_tick && (r_tick_cnt == T_END);
    assign w_maj     = maj3(r_s0, r_s1, w_rx);
    assign w_break   = ~|r_shift & ~r_par_bit & ~w_maj;

    uart_baud_gen #(
        .SystemClockFreq(SystemClockFreq),
        .BaudRate       (BaudRate),
        .OverSample     (OverSample)
    ) u_baud_gen (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_restart(w_restart),
        .o_tick   (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // The last stop bit is resolved at mid-bit so a back-to-back start edge is never missed.
    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_ferr_fin = 1'b0;
        w_brk_fin  = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_fall) w_next = ST_START;
            ST_START: begin
                if (w_decide && w_maj) w_next = ST_IDLE;
                else if (w_end)        w_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_end && (r_bit_cnt == 4'(DataLength - 1)))
                    w_next = (r_par_mode == PAR_NONE) ? ST_STOP1 : ST_PARITY;
            end
            ST_PARITY: if (w_end) w_next = ST_STOP1;
            ST_STOP1: begin
                if (w_decide) begin
                    if (w_break) begin
                        w_next     = ST_BREAK_WAIT;
                        w_done     = 1'b1;
                        w_ferr_fin = 1'b1;
                        w_brk_fin  = 1'b1;
                    end else if (!r_two_stop) begin
                        w_next     = ST_IDLE;
                        w_done     = 1'b1;
                        w_ferr_fin = ~w_maj;
                    end
                end else if (w_end && r_two_stop) begin
                    w_next = ST_STOP2;
                end
            end
            ST_STOP2: begin
                if (w_decide) begin
                    w_next     = ST_IDLE;
                    w_done     = 1'b1;
                    w_ferr_fin = r_ferr | ~w_maj;
                end
            end
            ST_BREAK_WAIT: if (w_rx && w_end) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_bit      <= 1'b1;
            r_shift    <= '0;
            r_par_mode <= PAR_NONE;
            r_two_stop <= 1'b0;
            r_par_bit  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
        end else begin
            if (w_restart) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                r_par_mode <= i_parity;
                r_two_stop <= i_two_stop;
                r_par_bit  <= 1'b0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
            end else if ((r_state != ST_BREAK_WAIT) && (w_next == ST_BREAK_WAIT)) begin
                r_tick_cnt <= '0;
            end else if ((r_state == ST_BREAK_WAIT) && !w_rx) begin
                r_tick_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= (r_tick_cnt == T_END) ? '0 : r_tick_cnt + 1'b1;
            end
            if (w_tick && (r_tick_cnt == T_S0)) r_s0 <= w_rx;
            if (w_tick && (r_tick_cnt == T_S1)) r_s1 <= w_rx;
            if (w_decide) r_bit <= w_maj;
            if ((r_state == ST_DATA) && w_end) begin
                r_shift   <= {r_bit, r_shift[DataLength-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if ((r_state == ST_PARITY) && w_end) begin
                r_par_bit <= r_bit;
                r_perr    <= r_bit ^ par_expected(r_par_mode, ^r_shift);
            end
            if ((r_state == ST_STOP1) && w_decide) r_ferr <= ~w_maj;
        end
    end

    // A word finishing while the consumer stalls is dropped; the held word stays intact.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_data <= '0;
            r_valid   <= 1'b0;
            r_perr_h  <= 1'b0;
            r_ferr_h  <= 1'b0;
            r_brk_h   <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            if (w_done && r_valid && !i_rx_ready) r_ovr <= 1'b1;
            else if (i_err_clr)                   r_ovr <= 1'b0;
            if (w_done && !(r_valid && !i_rx_ready)) begin
                r_rx_data <= r_shift;
                r_perr_h  <= r_perr;
                r_ferr_h  <= w_ferr_fin;
                r_brk_h   <= w_brk_fin;
                r_valid   <= 1'b1;
            end else if (r_valid && i_rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_valid;
    assign o_parity_err = r_perr_h;
    assign o_frame_err  = r_ferr_h;
    assign o_break      = r_brk_h;
    assign o_overrun    = r_ovr;
    assign o_rts        = ~r_valid;
    assign o_state      = r_state;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 16 clocks per bit; words are predicted
// from the frame contents and checked by a per-cycle monitor.
module tb_uart_rx_framer;
    import uart_pkg::*;

    localparam int BIT = 16;

    logic       clk = 1'b0;
    logic       rst_n, rx, two_stop, rx_ready, err_clr;
    parity_e    parity;
    logic [7:0] rx_data;
    logic       rx_valid, perr, ferr, brk, ovr, rts;
    rx_state_e  state;

    int total  = 0;
    int bad    = 0;
    int vcount = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_framer #(
        .DataLength     (8),
        .OverSample     (16),
        .BaudRate       (1_000_000),
        .SystemClockFreq(16_000_000)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_rx        (rx),
        .i_parity    (parity),
        .i_two_stop  (two_stop),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .i_rx_ready  (rx_ready),
        .o_parity_err(perr),
        .o_frame_err (ferr),
        .o_break     (brk),
        .o_overrun   (ovr),
        .i_err_clr   (err_clr),
        .o_rts       (rts),
        .o_state     (state)
    );

    // Expected held word {break, frame_err, parity_err, data} from the bits on the line.
    function automatic logic [10:0] exp_word(input logic [7:0] d, input parity_e pm,
                                             input logic pbit, input logic two,
                                             input logic s1, input logic s2);
        logic want, pe, pb, br, fe;
        want = (pm == PAR_EVEN) ? ^d : (pm == PAR_ODD) ? ~^d : 1'b0;
        pe   = (pm != PAR_NONE) && (pbit != want);
        pb   = (pm == PAR_NONE) ? 1'b0 : pbit;
        br   = (d == 8'h00) && !pb && !s1;
        fe   = !s1 || (two && !s2);
        return {br, fe, pe, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        step(BIT);
    endtask

    task automatic send_frame(input logic [7:0] d, input parity_e pm, input logic pbit,
                              input logic two, input logic s1, input logic s2,
                              input logic flip);
        parity   = pm;
        two_stop = two;
        send_bit(1'b0);
        if (flip) begin
            parity   = PAR_NONE;
            two_stop = 1'b0;
        end
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pm != PAR_NONE) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        rx = 1'b1;
        step(2 * BIT);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            step(1);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic monitor();
        logic        have, prev_valid, prev_ready;
        logic [10:0] prev_word, cur;
        have = 1'b0;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 1'b0;
                continue;
            end
            cur = {brk, ferr, perr, rx_data};
            if (rx_valid) vcount++;
            check("rts_vs_valid", rts, !rx_valid);
            if (have && prev_valid && !prev_ready && rx_valid)
                check("held_stable", cur, prev_word);
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h expected none", cur);
                end else begin
                    check("word", cur, exp_q.pop_front());
                end
            end
            have       = 1'b1;
            prev_valid = rx_valid;
            prev_ready = rx_ready;
            prev_word  = cur;
        end
    endtask

    initial begin
        int v0;
        rst_n    = 1'b0;
        rx       = 1'b1;
        parity   = PAR_NONE;
        two_stop = 1'b0;
        rx_ready = 1'b1;
        err_clr  = 1'b0;
        fork
            monitor();
            begin
                step(3);
                check("rst_valid", rx_valid, 0);
                check("rst_rts", rts, 1);
                check("rst_data", rx_data, 0);
                check("rst_flags", {brk, ferr, perr, ovr}, 0);
                check("rst_state", state, ST_IDLE);
                rst_n = 1'b1;
                step(5);

                check("model_8e1_bad_par", exp_word(8'h03, PAR_EVEN, 1, 0, 1, 1), 11'h103);
                check("model_break", exp_word(8'h00, PAR_NONE, 0, 0, 0, 1), 11'h600);
                check("model_8n1", exp_word(8'hA5, PAR_NONE, 0, 0, 1, 1), 11'h0A5);
                check("model_8o2_stop2", exp_word(8'h80, PAR_ODD, 0, 1, 1, 0), 11'h280);

                // 8N1 0xA5 with consumer always ready
                v0 = vcount;
                exp_q.push_back(exp_word(8'hA5, PAR_NONE, 0, 0, 1, 1));
                send_frame(8'hA5, PAR_NONE, 0, 0, 1, 1, 0);
                wait_drain("drain_a5");
                check("a5_valid_cycles", vcount - v0, 1);

                // 8E1 0x03 with wrong then right parity
                exp_q.push_back(exp_word(8'h03, PAR_EVEN, 1, 0, 1, 1));
                send_frame(8'h03, PAR_EVEN, 1, 0, 1, 1, 0);
                exp_q.push_back(exp_word(8'h03, PAR_EVEN, 0, 0, 1, 1));
                send_frame(8'h03, PAR_EVEN, 0, 0, 1, 1, 0);
                wait_drain("drain_parity");

                // 8O2, second stop bit low, config changed mid-frame
                exp_q.push_back(exp_word(8'h80, PAR_ODD, 0, 1, 1, 0));
                send_frame(8'h80, PAR_ODD, 0, 1, 1, 0, 1);
                wait_drain("drain_8o2");

                // short glitch, then a real frame
                parity   = PAR_NONE;
                two_stop = 1'b0;
                rx = 1'b0;
                step(4);
                rx = 1'b1;
                step(40);
                exp_q.push_back(exp_word(8'h5A, PAR_NONE, 0, 0, 1, 1));
                send_frame(8'h5A, PAR_NONE, 0, 0, 1, 1, 0);
                wait_drain("drain_glitch");

                // overrun while the consumer stalls
                rx_ready = 1'b0;
                send_frame(8'h11, PAR_NONE, 0, 0, 1, 1, 0);
                send_frame(8'h22, PAR_NONE, 0, 0, 1, 1, 0);
                check("ovr_data", rx_data, 8'h11);
                check("ovr_valid", rx_valid, 1);
                check("ovr_flag", ovr, 1);
                check("ovr_rts", rts, 0);
                err_clr = 1'b1;
                step(1);
                err_clr = 1'b0;
                check("ovr_cleared", ovr, 0);
                check("ovr_still_held", rx_data, 8'h11);
                exp_q.push_back(exp_word(8'h11, PAR_NONE, 0, 0, 1, 1));
                rx_ready = 1'b1;
                wait_drain("drain_ovr");

                // break: line low for 12 bit times
                exp_q.push_back(exp_word(8'h00, PAR_NONE, 0, 0, 0, 1));
                rx = 1'b0;
                step(12 * BIT);
                rx = 1'b1;
                wait_drain("drain_break");
                v0 = vcount;
                step(6 * BIT);
                check("break_no_extra", vcount - v0, 0);
                check("break_back_idle", state, ST_IDLE);

                // reset in the middle of data bit 3, with a word held and overrun set
                rx_ready = 1'b0;
                send_frame(8'h77, PAR_NONE, 0, 0, 1, 1, 0);
                send_frame(8'h78, PAR_NONE, 0, 0, 1, 1, 0);
                check("pre_rst_data", rx_data, 8'h77);
                check("pre_rst_ovr", ovr, 1);
                send_bit(1'b0);
                send_bit(1'b1);
                send_bit(1'b1);
                send_bit(1'b0);
                rx = 1'b0;
                step(8);
                rst_n = 1'b0;
                #1;
                check("mid_rst_valid", rx_valid, 0);
                check("mid_rst_data", rx_data, 0);
                check("mid_rst_flags", {brk, ferr, perr, ovr}, 0);
                check("mid_rst_rts", rts, 1);
                rx = 1'b1;
                step(3);
                rst_n = 1'b1;
                step(40);
                check("post_rst_valid", rx_valid, 0);
                check("post_rst_state", state, ST_IDLE);
                rx_ready = 1'b1;
                exp_q.push_back(exp_word(8'hC3, PAR_NONE, 0, 0, 1, 1));
                send_frame(8'hC3, PAR_NONE, 0, 0, 1, 1, 0);
                wait_drain("drain_c3");

                step(50);
                check("final_queue_empty", exp_q.size(), 0);
            end
        join_any
        disable fork;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
